// File: rtl/ahb_slave_mem8.sv
// 8-bit AHB-Lite memory slave: programmable wait states, read-after-write forwarding.
// Define SLAVE_MEM_ERR_RESP_EN to return a two-cycle ERROR for HADDR >= MEM_DEPTH.
module ahb_slave_mem8 #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [7:0]            HWDATA,
  input  logic                  HREADY,
  output logic [7:0]            HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t           state, state_n;
  logic [3:0]       wcnt, wcnt_n;
  logic [IDX_W-1:0] lat_idx, rd_idx;
  logic             lat_write;
  logic             lat_err;
  logic             addr_err;
  logic             ready_int;
  logic             addr_valid;
  logic             wr_commit;
  logic             rd_load;
  logic [7:0]       rd_data;
  logic [7:0]       mem [MEM_DEPTH];
  logic             unused_bits;

  assign ready_int  = (state != ST_WAIT) && (state != ST_ERR1);
  assign addr_valid = ready_int & HSEL & HTRANS[1] & HREADY;
  assign HREADYOUT  = ready_int;
  assign unused_bits = ^{HTRANS[0], HADDR};

`ifdef SLAVE_MEM_ERR_RESP_EN
  assign addr_err = ({1'b0, HADDR} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));
  assign HRESP    = (state == ST_ERR1) || (state == ST_ERR2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_err <= 1'b0;
    end else if (addr_valid) begin
      lat_err <= addr_err;
    end
  end
`else
  assign addr_err = 1'b0;
  assign lat_err  = 1'b0;
  assign HRESP    = 1'b0;
`endif

  // A read entering DATA straight from an address phase uses the live HADDR;
  // after wait states it uses the latched index. A write completing in the
  // same cycle to the same index is forwarded so the read never sees stale data.
  assign rd_idx    = (state == ST_WAIT) ? lat_idx : HADDR[IDX_W-1:0];
  assign wr_commit = (state == ST_DATA) && lat_write;
  assign rd_data   = (wr_commit && (lat_idx == rd_idx)) ? HWDATA : mem[rd_idx];

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    rd_load = 1'b0;
    unique case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (addr_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_n = ST_WAIT;
            wcnt_n  = 4'(WAIT_CYCLES - 1);
          end else if (addr_err) begin
            state_n = ST_ERR1;
          end else begin
            state_n = ST_DATA;
            rd_load = !HWRITE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt == '0) begin
          if (lat_err) begin
            state_n = ST_ERR1;
          end else begin
            state_n = ST_DATA;
            rd_load = !lat_write;
          end
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      ST_ERR1: state_n = ST_ERR2;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      HRDATA    <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (addr_valid) begin
        lat_idx   <= HADDR[IDX_W-1:0];
        lat_write <= HWRITE;
      end
      if (rd_load) begin
        HRDATA <= rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      mem[lat_idx] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem8.sv
// Bench for ahb_slave_mem8: three slaves (0, 1 and 3 wait states) checked every
// cycle against a transfer-timeline model, plus directed literal checks.
module tb_ahb_slave_mem8;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;
  localparam int unsigned WT0 = 0, WT1 = 1, WT2 = 3;

  function automatic int wt(input int d);
    return (d == 0) ? int'(WT0) : (d == 1) ? int'(WT1) : int'(WT2);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NDUT-1:0] hsel, hwrite, hready, hreadyout, hresp;
  logic [1:0] htrans [NDUT];
  logic [7:0] haddr [NDUT];
  logic [7:0] hwdata [NDUT];
  logic [7:0] hrdata [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_slave_mem8 #(
      .ADDR_WIDTH (8),
      .MEM_DEPTH  (DEPTH),
      .WAIT_CYCLES(g == 0 ? WT0 : g == 1 ? WT1 : WT2)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .HSEL     (hsel[g]),
      .HADDR    (haddr[g]),
      .HTRANS   (htrans[g]),
      .HWRITE   (hwrite[g]),
      .HWDATA   (hwdata[g]),
      .HREADY   (hready[g]),
      .HRDATA   (hrdata[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g])
    );
  end

  // Each accepted transfer is expanded into its future cycles (ready, resp,
  // completion); the bench pops one slot per cycle.
  typedef struct packed {
    logic       rdy;
    logic       resp;
    logic       fin;
    logic       wr;
    logic [5:0] idx;
  } slot_t;

  slot_t      sched [NDUT][$];
  logic [7:0] mem_m [NDUT][DEPTH];
  logic       exp_rdy [NDUT];
  logic       exp_resp [NDUT];
  logic [7:0] exp_rdata [NDUT];
  logic       zero_next [NDUT];

  logic       w_sel [NDUT];
  logic       w_write [NDUT];
  logic [1:0] w_trans [NDUT];
  logic [7:0] w_addr [NDUT];
  logic [7:0] w_data [NDUT];
  logic       w_rst;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic bit is_err(input logic [7:0] a);
`ifdef SLAVE_MEM_ERR_RESP_EN
    return a >= 8'd64;
`else
    return (a != a);
`endif
  endfunction

  task automatic tick();
    slot_t cur, s;
    for (int d = 0; d < NDUT; d++) begin
      if (sched[d].size() > 0) cur = sched[d].pop_front();
      else cur = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
      if (zero_next[d]) begin
        exp_rdata[d] = 8'h00;
        zero_next[d] = 1'b0;
      end
      if (cur.fin && !cur.wr && !cur.resp) exp_rdata[d] = mem_m[d][cur.idx];
      exp_rdy[d]  = cur.rdy;
      exp_resp[d] = cur.resp;
      hready[d] = cur.rdy;
      hsel[d]   = w_sel[d];
      htrans[d] = w_trans[d];
      hwrite[d] = w_write[d];
      haddr[d]  = w_addr[d];
      hwdata[d] = w_data[d];
      if (w_rst) begin
        sched[d].delete();
        zero_next[d] = 1'b1;
      end else begin
        if (cur.fin && cur.wr && !cur.resp) mem_m[d][cur.idx] = w_data[d];
        if (cur.rdy && w_sel[d] && w_trans[d][1]) begin
          for (int k = 0; k < wt(d); k++) begin
            s = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
            sched[d].push_back(s);
          end
          if (is_err(w_addr[d])) begin
            s = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
            sched[d].push_back(s);
            s = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
            sched[d].push_back(s);
          end else begin
            s = '{1'b1, 1'b0, 1'b1, w_write[d], w_addr[d][5:0]};
            sched[d].push_back(s);
          end
        end
      end
    end
    rst_n = !w_rst;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        n_cmp++;
        if (hreadyout[d] !== exp_rdy[d] || hresp[d] !== exp_resp[d] || hrdata[d] !== exp_rdata[d]) begin
          n_bad++;
          $display("FAIL bus d%0d t=%0t: rdy=%b resp=%b rdata=%h, expected rdy=%b resp=%b rdata=%h",
                   d, $time, hreadyout[d], hresp[d], hrdata[d], exp_rdy[d], exp_resp[d], exp_rdata[d]);
        end
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_idle();
    for (int d = 0; d < NDUT; d++) begin
      w_sel[d] = 1'b0; w_trans[d] = 2'b00; w_write[d] = 1'b0;
      w_addr[d] = 8'h00; w_data[d] = 8'h00;
    end
    w_rst = 1'b0;
  endtask

  task automatic addr_phase(input int d, input logic wr, input logic [7:0] a, input logic [7:0] data);
    w_sel[d] = 1'b1; w_trans[d] = 2'b10; w_write[d] = wr; w_addr[d] = a; w_data[d] = data;
    tick();
    w_sel[d] = 1'b0; w_trans[d] = 2'b00;
  endtask

  task automatic do_xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] data);
    addr_phase(d, wr, a, data);
    while (sched[d].size() > 0) tick();
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) zero_next[d] = 1'b0;
    set_idle();
    w_rst = 1'b1;
    tick();
    tick();
    w_rst = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      chk8("reset_hrdata", hrdata[d], 8'h00);
      chk1("reset_hreadyout", hreadyout[d], 1'b1);
      chk1("reset_hresp", hresp[d], 1'b0);
    end

    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < DEPTH; i++) do_xfer(d, 1'b1, 8'(i), 8'(i) ^ 8'h5A);

    // one wait state: write A5@10 then read it back
    addr_phase(1, 1'b1, 8'h10, 8'hA5);
    chk1("w1_wr_stall", hreadyout[1], 1'b0);
    tick();
    chk1("w1_wr_done", hreadyout[1], 1'b1);
    tick();
    addr_phase(1, 1'b0, 8'h10, 8'h00);
    chk1("w1_rd_stall", hreadyout[1], 1'b0);
    tick();
    chk1("w1_rd_done", hreadyout[1], 1'b1);
    chk8("w1_rd_data", hrdata[1], 8'hA5);
    tick();

    // zero wait: write 3C@05 with back-to-back read of the same location
    addr_phase(0, 1'b1, 8'h05, 8'h3C);
    chk1("w0_wr_nostall", hreadyout[0], 1'b1);
    addr_phase(0, 1'b0, 8'h05, 8'h3C);
    chk1("w0_rd_nostall", hreadyout[0], 1'b1);
    chk8("w0_raw_fwd", hrdata[0], 8'h3C);
    tick();

    addr_phase(0, 1'b0, 8'h50, 8'h00);
`ifdef SLAVE_MEM_ERR_RESP_EN
    chk1("err1_rdy", hreadyout[0], 1'b0);
    chk1("err1_resp", hresp[0], 1'b1);
    tick();
    chk1("err2_rdy", hreadyout[0], 1'b1);
    chk1("err2_resp", hresp[0], 1'b1);
    chk8("err_hrdata_held", hrdata[0], 8'h3C);
`else
    chk1("wrap_rdy", hreadyout[0], 1'b1);
    chk8("wrap_rdata", hrdata[0], 8'h4A);
`endif
    tick();

    // reset while a write is still in its wait state
    do_xfer(1, 1'b1, 8'h20, 8'h11);
    addr_phase(1, 1'b1, 8'h20, 8'h77);
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    chk1("rst_wait_rdy", hreadyout[1], 1'b1);
    chk8("rst_wait_hrdata", hrdata[1], 8'h00);
    addr_phase(1, 1'b0, 8'h20, 8'h00);
    tick();
    chk8("rst_no_commit", hrdata[1], 8'h11);
    tick();

    // unselected / IDLE / BUSY writes must not touch memory
    for (int p = 0; p < 3; p++) begin
      w_sel[0] = (p != 0); w_trans[0] = (p == 0) ? 2'b10 : (p == 1) ? 2'b00 : 2'b01;
      w_write[0] = 1'b1; w_addr[0] = 8'h05; w_data[0] = 8'hFF;
      tick();
      chk1("nosel_rdy", hreadyout[0], 1'b1);
      chk1("nosel_resp", hresp[0], 1'b0);
      tick();
    end
    set_idle();
    addr_phase(0, 1'b0, 8'h05, 8'h00);
    chk8("nosel_mem_kept", hrdata[0], 8'h3C);
    tick();

    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        w_sel[d]   = ($urandom_range(3, 0) != 0);
        w_trans[d] = 2'($urandom_range(3, 0));
        w_write[d] = 1'($urandom_range(1, 0));
        w_addr[d]  = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(7, 0));
        w_data[d]  = 8'($urandom);
      end
      w_rst = ($urandom_range(96, 0) == 0);
      tick();
    end

    set_idle();
    for (int c = 0; c < 8; c++) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
